// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the byte-serial inverse AES column datapath.
package aes_inv_pkg;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  localparam logic [7:0] GF_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // byte0 is [31:24]; each output row is the previous one rotated by a byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    {a0, a1, a2, a3} = w;
    o0 = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    o1 = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    o2 = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    o3 = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    return {o0, o1, o2, o3};
  endfunction

endpackage

// File: rtl/aes_inv_column_inv_sbox.sv
// Registered AES inverse S-box, one-cycle latency.
module inv_sbox (
  input  logic       clk,
  input  logic [7:0] in,
  output logic [7:0] out
);

  logic [7:0] lut;

  always_comb begin
    lut = '0;
    case (in)
      8'h00:lut=8'h52; 8'h01:lut=8'h09; 8'h02:lut=8'h6a; 8'h03:lut=8'hd5; 8'h04:lut=8'h30; 8'h05:lut=8'h36; 8'h06:lut=8'ha5; 8'h07:lut=8'h38;
      8'h08:lut=8'hbf; 8'h09:lut=8'h40; 8'h0a:lut=8'ha3; 8'h0b:lut=8'h9e; 8'h0c:lut=8'h81; 8'h0d:lut=8'hf3; 8'h0e:lut=8'hd7; 8'h0f:lut=8'hfb;
      8'h10:lut=8'h7c; 8'h11:lut=8'he3; 8'h12:lut=8'h39; 8'h13:lut=8'h82; 8'h14:lut=8'h9b; 8'h15:lut=8'h2f; 8'h16:lut=8'hff; 8'h17:lut=8'h87;
      8'h18:lut=8'h34; 8'h19:lut=8'h8e; 8'h1a:lut=8'h43; 8'h1b:lut=8'h44; 8'h1c:lut=8'hc4; 8'h1d:lut=8'hde; 8'h1e:lut=8'he9; 8'h1f:lut=8'hcb;
      8'h20:lut=8'h54; 8'h21:lut=8'h7b; 8'h22:lut=8'h94; 8'h23:lut=8'h32; 8'h24:lut=8'ha6; 8'h25:lut=8'hc2; 8'h26:lut=8'h23; 8'h27:lut=8'h3d;
      8'h28:lut=8'hee; 8'h29:lut=8'h4c; 8'h2a:lut=8'h95; 8'h2b:lut=8'h0b; 8'h2c:lut=8'h42; 8'h2d:lut=8'hfa; 8'h2e:lut=8'hc3; 8'h2f:lut=8'h4e;
      8'h30:lut=8'h08; 8'h31:lut=8'h2e; 8'h32:lut=8'ha1; 8'h33:lut=8'h66; 8'h34:lut=8'h28; 8'h35:lut=8'hd9; 8'h36:lut=8'h24; 8'h37:lut=8'hb2;
      8'h38:lut=8'h76; 8'h39:lut=8'h5b; 8'h3a:lut=8'ha2; 8'h3b:lut=8'h49; 8'h3c:lut=8'h6d; 8'h3d:lut=8'h8b; 8'h3e:lut=8'hd1; 8'h3f:lut=8'h25;
      8'h40:lut=8'h72; 8'h41:lut=8'hf8; 8'h42:lut=8'hf6; 8'h43:lut=8'h64; 8'h44:lut=8'h86; 8'h45:lut=8'h68; 8'h46:lut=8'h98; 8'h47:lut=8'h16;
      8'h48:lut=8'hd4; 8'h49:lut=8'ha4; 8'h4a:lut=8'h5c; 8'h4b:lut=8'hcc; 8'h4c:lut=8'h5d; 8'h4d:lut=8'h65; 8'h4e:lut=8'hb6; 8'h4f:lut=8'h92;
      8'h50:lut=8'h6c; 8'h51:lut=8'h70; 8'h52:lut=8'h48; 8'h53:lut=8'h50; 8'h54:lut=8'hfd; 8'h55:lut=8'hed; 8'h56:lut=8'hb9; 8'h57:lut=8'hda;
      8'h58:lut=8'h5e; 8'h59:lut=8'h15; 8'h5a:lut=8'h46; 8'h5b:lut=8'h57; 8'h5c:lut=8'ha7; 8'h5d:lut=8'h8d; 8'h5e:lut=8'h9d; 8'h5f:lut=8'h84;
      8'h60:lut=8'h90; 8'h61:lut=8'hd8; 8'h62:lut=8'hab; 8'h63:lut=8'h00; 8'h64:lut=8'h8c; 8'h65:lut=8'hbc; 8'h66:lut=8'hd3; 8'h67:lut=8'h0a;
      8'h68:lut=8'hf7; 8'h69:lut=8'he4; 8'h6a:lut=8'h58; 8'h6b:lut=8'h05; 8'h6c:lut=8'hb8; 8'h6d:lut=8'hb3; 8'h6e:lut=8'h45; 8'h6f:lut=8'h06;
      8'h70:lut=8'hd0; 8'h71:lut=8'h2c; 8'h72:lut=8'h1e; 8'h73:lut=8'h8f; 8'h74:lut=8'hca; 8'h75:lut=8'h3f; 8'h76:lut=8'h0f; 8'h77:lut=8'h02;
      8'h78:lut=8'hc1; 8'h79:lut=8'haf; 8'h7a:lut=8'hbd; 8'h7b:lut=8'h03; 8'h7c:lut=8'h01; 8'h7d:lut=8'h13; 8'h7e:lut=8'h8a; 8'h7f:lut=8'h6b;
      8'h80:lut=8'h3a; 8'h81:lut=8'h91; 8'h82:lut=8'h11; 8'h83:lut=8'h41; 8'h84:lut=8'h4f; 8'h85:lut=8'h67; 8'h86:lut=8'hdc; 8'h87:lut=8'hea;
      8'h88:lut=8'h97; 8'h89:lut=8'hf2; 8'h8a:lut=8'hcf; 8'h8b:lut=8'hce; 8'h8c:lut=8'hf0; 8'h8d:lut=8'hb4; 8'h8e:lut=8'he6; 8'h8f:lut=8'h73;
      8'h90:lut=8'h96; 8'h91:lut=8'hac; 8'h92:lut=8'h74; 8'h93:lut=8'h22; 8'h94:lut=8'he7; 8'h95:lut=8'had; 8'h96:lut=8'h35; 8'h97:lut=8'h85;
      8'h98:lut=8'he2; 8'h99:lut=8'hf9; 8'h9a:lut=8'h37; 8'h9b:lut=8'he8; 8'h9c:lut=8'h1c; 8'h9d:lut=8'h75; 8'h9e:lut=8'hdf; 8'h9f:lut=8'h6e;
      8'ha0:lut=8'h47; 8'ha1:lut=8'hf1; 8'ha2:lut=8'h1a; 8'ha3:lut=8'h71; 8'ha4:lut=8'h1d; 8'ha5:lut=8'h29; 8'ha6:lut=8'hc5; 8'ha7:lut=8'h89;
      8'ha8:lut=8'h6f; 8'ha9:lut=8'hb7; 8'haa:lut=8'h62; 8'hab:lut=8'h0e; 8'hac:lut=8'haa; 8'had:lut=8'h18; 8'hae:lut=8'hbe; 8'haf:lut=8'h1b;
      8'hb0:lut=8'hfc; 8'hb1:lut=8'h56; 8'hb2:lut=8'h3e; 8'hb3:lut=8'h4b; 8'hb4:lut=8'hc6; 8'hb5:lut=8'hd2; 8'hb6:lut=8'h79; 8'hb7:lut=8'h20;
      8'hb8:lut=8'h9a; 8'hb9:lut=8'hdb; 8'hba:lut=8'hc0; 8'hbb:lut=8'hfe; 8'hbc:lut=8'h78; 8'hbd:lut=8'hcd; 8'hbe:lut=8'h5a; 8'hbf:lut=8'hf4;
      8'hc0:lut=8'h1f; 8'hc1:lut=8'hdd; 8'hc2:lut=8'ha8; 8'hc3:lut=8'h33; 8'hc4:lut=8'h88; 8'hc5:lut=8'h07; 8'hc6:lut=8'hc7; 8'hc7:lut=8'h31;
      8'hc8:lut=8'hb1; 8'hc9:lut=8'h12; 8'hca:lut=8'h10; 8'hcb:lut=8'h59; 8'hcc:lut=8'h27; 8'hcd:lut=8'h80; 8'hce:lut=8'hec; 8'hcf:lut=8'h5f;
      8'hd0:lut=8'h60; 8'hd1:lut=8'h51; 8'hd2:lut=8'h7f; 8'hd3:lut=8'ha9; 8'hd4:lut=8'h19; 8'hd5:lut=8'hb5; 8'hd6:lut=8'h4a; 8'hd7:lut=8'h0d;
      8'hd8:lut=8'h2d; 8'hd9:lut=8'he5; 8'hda:lut=8'h7a; 8'hdb:lut=8'h9f; 8'hdc:lut=8'h93; 8'hdd:lut=8'hc9; 8'hde:lut=8'h9c; 8'hdf:lut=8'hef;
      8'he0:lut=8'ha0; 8'he1:lut=8'he0; 8'he2:lut=8'h3b; 8'he3:lut=8'h4d; 8'he4:lut=8'hae; 8'he5:lut=8'h2a; 8'he6:lut=8'hf5; 8'he7:lut=8'hb0;
      8'he8:lut=8'hc8; 8'he9:lut=8'heb; 8'hea:lut=8'hbb; 8'heb:lut=8'h3c; 8'hec:lut=8'h83; 8'hed:lut=8'h53; 8'hee:lut=8'h99; 8'hef:lut=8'h61;
      8'hf0:lut=8'h17; 8'hf1:lut=8'h2b; 8'hf2:lut=8'h04; 8'hf3:lut=8'h7e; 8'hf4:lut=8'hba; 8'hf5:lut=8'h77; 8'hf6:lut=8'hd6; 8'hf7:lut=8'h26;
      8'hf8:lut=8'he1; 8'hf9:lut=8'h69; 8'hfa:lut=8'h14; 8'hfb:lut=8'h63; 8'hfc:lut=8'h55; 8'hfd:lut=8'h21; 8'hfe:lut=8'h0c; 8'hff:lut=8'h7d;
    endcase
  end

  always_ff @(posedge clk) begin
    out <= lut;
  end

endmodule

// File: rtl/aes_inv_column.sv
// One AES decryption column per transaction: InvSubBytes, AddRoundKey, InvMixColumns (skipped on last).
// Optional completed-word counter on done_cnt when AES_INV_CNT_EN is defined.
module aes_inv_column
  import aes_inv_pkg::*;
`ifdef AES_INV_CNT_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [31:0]      in_state,
  input  logic [31:0]      in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
`ifdef AES_INV_CNT_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] st_q, key_q, sub_q;
  logic        last_q;
  logic [7:0]  sbox_out;

  // Address always comes from the top byte; shifting st_q walks byte0..byte3.
  inv_sbox u_sbox (
    .clk (clk),
    .in  (st_q[31:24]),
    .out (sbox_out)
  );

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = SUB;
      SUB:  if (cnt_q == 3'd4) state_d = MIX;
      MIX:  state_d = DONE;
      DONE: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      st_q      <= '0;
      key_q     <= '0;
      sub_q     <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef AES_INV_CNT_EN
      done_cnt  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q   <= in_state;
            key_q  <= in_key;
            last_q <= in_last;
            cnt_q  <= '0;
          end
        end
        SUB: begin
          cnt_q <= cnt_q + 3'd1;
          st_q  <= {st_q[23:0], 8'h00};
          if (cnt_q != 3'd0) begin
            sub_q <= {sub_q[23:0], sbox_out ^ key_q[31:24]};
            key_q <= {key_q[23:0], 8'h00};
          end
        end
        MIX: out_data <= last_q ? sub_q : inv_mix_col(sub_q);
        DONE: begin
          // out_valid is a flop raised one cycle into DONE so it is glitch-free at the port
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
`ifdef AES_INV_CNT_EN
            done_cnt  <= done_cnt + CNT_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_column.sv
// Randomized self-checking bench for aes_inv_column against a GF(2^8) reference model.
module tb_aes_inv_column;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_state, in_key;
  logic        out_valid, out_ready;
  logic [31:0] out_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  isb [256];
  int unsigned cnt_m = 0;

`ifdef AES_INV_CNT_EN
  localparam int unsigned CW = 2;
  logic [CW-1:0] done_cnt;
  aes_inv_column #(.CNT_W(CW)) dut (
`else
  aes_inv_column dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_state  (in_state),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AES_INV_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Forward S-box from field inverse plus affine map, then inverted into isb
  task automatic build_isb();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] st, input logic [31:0] key, input logic last);
    logic [7:0] a [4];
    logic [7:0] o [4];
    logic [7:0] cf [4];
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    for (int i = 0; i < 4; i++) a[i] = isb[st[31-8*i -: 8]] ^ key[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      o[i] = 8'h00;
      for (int j = 0; j < 4; j++) o[i] ^= gmul(cf[(j - i) & 3], a[j]);
      if (last) o[i] = a[i];
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  task automatic run_txn(input logic [31:0] st, input logic [31:0] key, input logic last,
                         input logic [31:0] exp, input int unsigned hold);
    int unsigned lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_state = st; in_key = key; in_last = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_state = $urandom; in_key = $urandom; in_last = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", 32'(lat), 32'd7);
    check("out_data", out_data, exp);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    out_ready = (hold == 0);
    for (int k = 0; k < int'(hold); k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, exp);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
    check("data_held", out_data, exp);
    cnt_m++;
`ifdef AES_INV_CNT_EN
    check("done_cnt", 32'(done_cnt), cnt_m % (1 << CW));
`endif
  endtask

  initial begin
    logic [31:0] st, key;
    logic        last;
    build_isb();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_state = '0; in_key = '0; out_ready = 1'b1;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
`ifdef AES_INV_CNT_EN
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // idle with in_valid low must not start anything
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid", 32'(out_valid), 32'd0);

    run_txn(32'h637c777b, 32'h00000000, 1'b1, 32'h00010203, 0);
    run_txn(32'h637c777b, 32'hffffffff, 1'b1, 32'hfffefdfc, 0);
    run_txn(32'h19e33265, 32'h00000000, 1'b0, 32'hdb135345, 0);
    run_txn(32'h19e33265, 32'h00000000, 1'b0, 32'hdb135345, 10);

    // abandon a transaction in SUB cnt=2
    @(negedge clk);
    in_valid = 1'b1; in_state = 32'h19e33265; in_key = 32'h0; in_last = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_data", out_data, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    check("no_ghost_out", 32'(out_valid), 32'd0);
    run_txn(32'h637c777b, 32'h00000000, 1'b1, 32'h00010203, 0);

    for (int t = 0; t < 30; t++) begin
      st = $urandom; key = $urandom; last = 1'($urandom);
      run_txn(st, key, last, model(st, key, last), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
